// File: rtl/network_source_multi_if.sv
// Handshake bundle between the host deserialiser (src_*) and the spiking network core (net_*).
// master = host/network side, slave = the dispatcher.
interface network_source_multi_if #(
    parameter int unsigned NUM_INP      = 1,
    parameter int unsigned CHARGE_WIDTH = 8,
    parameter int unsigned RUN_WIDTH    = 16,
    parameter int unsigned SPK_LANES    = 2
);
    localparam int unsigned IDX_W  = (NUM_INP > 1) ? $clog2(NUM_INP) : 1;
    localparam int unsigned LANE_W = 1 + IDX_W + CHARGE_WIDTH;
    localparam int unsigned SPK_W  = SPK_LANES * LANE_W;
    localparam int unsigned PAY_W  = (RUN_WIDTH > SPK_W) ? RUN_WIDTH : SPK_W;
    localparam int unsigned SRC_W  = 2 + PAY_W;

    logic                           src_valid;
    logic                           src_ready;
    logic [SRC_W-1:0]               src;
    logic                           net_ready;
    logic                           net_valid;
    logic                           net_arstn;
    logic signed [CHARGE_WIDTH-1:0] net_inp [NUM_INP];

    modport master (
        output src_valid, src, net_ready,
        input  src_ready, net_valid, net_arstn, net_inp
    );

    modport slave (
        input  src_valid, src, net_ready,
        output src_ready, net_valid, net_arstn, net_inp
    );
endinterface

// File: rtl/network_source_multi.sv
// Network input dispatcher: decodes NOP/RUN/SPK/CLR words into per-input charges, a run
// handshake towards the network core, a sticky range error and a network-cycle counter.
module network_source_multi #(
    parameter int unsigned NUM_INP      = 1,
    parameter int unsigned CHARGE_WIDTH = 8,
    parameter int unsigned RUN_WIDTH    = 16,
    parameter int unsigned SPK_LANES    = 2,
    parameter int unsigned ACCUMULATE   = 0,
    parameter int unsigned CNT_WIDTH    = 32
) (
    input  logic                 clk,
    input  logic                 arstn,
    network_source_multi_if.slave bus,
    output logic                 err,
    output logic [CNT_WIDTH-1:0] cycles
);
    localparam int unsigned OPC_W  = 2;
    localparam int unsigned IDX_W  = (NUM_INP > 1) ? $clog2(NUM_INP) : 1;
    localparam int unsigned LANE_W = 1 + IDX_W + CHARGE_WIDTH;
    localparam int unsigned SPK_W  = SPK_LANES * LANE_W;
    localparam int unsigned PAY_W  = (RUN_WIDTH > SPK_W) ? RUN_WIDTH : SPK_W;
    localparam int unsigned SRC_W  = OPC_W + PAY_W;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP = 2'd0,
        OP_RUN = 2'd1,
        OP_SPK = 2'd2,
        OP_CLR = 2'd3
    } opc_e;

    typedef logic signed [CHARGE_WIDTH-1:0] charge_t;

    logic [RUN_WIDTH-1:0] run_q, run_d;
    charge_t              inp_q [NUM_INP];
    charge_t              inp_d [NUM_INP];
    logic                 err_q, err_d;
    logic [CNT_WIDTH-1:0] cyc_q, cyc_d;
    logic                 narst_q, narst_d;

    opc_e                 opc;
    logic [PAY_W-1:0]     payload;
    logic [RUN_WIDTH-1:0] run_val;
    logic                 src_ready_c;
    logic                 net_valid_c;
    logic                 accept_c;
    logic                 handshake_c;

    logic [SPK_LANES-1:0] lane_en;
    logic [IDX_W-1:0]     lane_idx [SPK_LANES];
    charge_t              lane_val [SPK_LANES];

    assign opc     = opc_e'(bus.src[SRC_W-1 -: OPC_W]);
    assign payload = bus.src[PAY_W-1:0];
    assign run_val = payload[PAY_W-1 -: RUN_WIDTH];

    // A new word may enter while idle or in the very cycle the last network cycle completes.
    assign net_valid_c = (run_q != '0);
    assign src_ready_c = (run_q == '0) || ((run_q == RUN_WIDTH'(1)) && bus.net_ready);
    assign accept_c    = bus.src_valid && src_ready_c;
    assign handshake_c = net_valid_c && bus.net_ready;

    // Lane 0 sits just below the opcode; later lanes follow towards the LSB.
    for (genvar k = 0; k < SPK_LANES; k++) begin : g_lane
        localparam int unsigned TOP = PAY_W - 1 - k * LANE_W;
        assign lane_en[k]  = payload[TOP];
        assign lane_idx[k] = payload[TOP-1 -: IDX_W];
        assign lane_val[k] = payload[TOP-1-IDX_W -: CHARGE_WIDTH];
    end

    function automatic charge_t sat_add(input charge_t a, input charge_t b);
        logic signed [CHARGE_WIDTH:0] s;
        s = {a[CHARGE_WIDTH-1], a} + {b[CHARGE_WIDTH-1], b};
        if (s[CHARGE_WIDTH] != s[CHARGE_WIDTH-1]) begin
            return s[CHARGE_WIDTH] ? {1'b1, {(CHARGE_WIDTH-1){1'b0}}}
                                   : {1'b0, {(CHARGE_WIDTH-1){1'b1}}};
        end
        return s[CHARGE_WIDTH-1:0];
    endfunction

    // Next state: the handshake clear is applied first so same-cycle spikes land in the next run.
    always_comb begin
        logic hit;
        run_d   = run_q;
        inp_d   = inp_q;
        err_d   = err_q;
        cyc_d   = cyc_q;
        narst_d = 1'b1;
        hit     = 1'b0;

        if (handshake_c) begin
            run_d = run_q - RUN_WIDTH'(1);
            cyc_d = cyc_q + CNT_WIDTH'(1);
            inp_d = '{default: '0};
        end

        if (accept_c) begin
            case (opc)
                OP_RUN: run_d = (run_val == '0) ? RUN_WIDTH'(1) : run_val;
                OP_SPK: begin
                    for (int k = 0; k < SPK_LANES; k++) begin
                        if (lane_en[k]) begin
                            hit = 1'b0;
                            for (int i = 0; i < NUM_INP; i++) begin
                                if (lane_idx[k] == IDX_W'(i)) begin
                                    hit      = 1'b1;
                                    inp_d[i] = (ACCUMULATE != 0) ? sat_add(inp_d[i], lane_val[k])
                                                                 : lane_val[k];
                                end
                            end
                            if (!hit) err_d = 1'b1;
                        end
                    end
                end
                OP_CLR: begin
                    narst_d = 1'b0;
                    inp_d   = '{default: '0};
                    err_d   = 1'b0;
                    cyc_d   = '0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            run_q   <= '0;
            inp_q   <= '{default: '0};
            err_q   <= 1'b0;
            cyc_q   <= '0;
            narst_q <= 1'b0;
        end else begin
            run_q   <= run_d;
            inp_q   <= inp_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            narst_q <= narst_d;
        end
    end

    assign bus.src_ready = src_ready_c;
    assign bus.net_valid = net_valid_c;
    assign bus.net_arstn = narst_q;
    assign bus.net_inp   = inp_q;
    assign err           = err_q;
    assign cycles        = cyc_q;
endmodule

// File: tb/tb_network_source_multi.sv
// Scoreboard bench: two dispatchers (overwrite and accumulate) share one instruction stream;
// a transaction-level model predicts every network handshake.
module tb_network_source_multi;
    localparam int unsigned NI = 3;
    localparam int unsigned CW = 8;
    localparam int unsigned RW = 16;
    localparam int unsigned NL = 2;

    logic        clk   = 1'b0;
    logic        arstn = 1'b0;
    logic        err_a, err_b;
    logic [31:0] cyc_a, cyc_b;

    network_source_multi_if #(.NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW), .SPK_LANES(NL)) ia ();
    network_source_multi_if #(.NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW), .SPK_LANES(NL)) ib ();

    network_source_multi #(.NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW), .SPK_LANES(NL),
                           .ACCUMULATE(0), .CNT_WIDTH(32)) dut_a (
        .clk(clk), .arstn(arstn), .bus(ia), .err(err_a), .cycles(cyc_a));
    network_source_multi #(.NUM_INP(NI), .CHARGE_WIDTH(CW), .RUN_WIDTH(RW), .SPK_LANES(NL),
                           .ACCUMULATE(1), .CNT_WIDTH(32)) dut_b (
        .clk(clk), .arstn(arstn), .bus(ib), .err(err_b), .cycles(cyc_b));

    always #5 clk = ~clk;

    typedef struct packed {
        logic [23:0] a;
        logic [23:0] b;
        logic [31:0] cyc;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    int          pa[3];
    int          pb[3];
    int unsigned mcyc     = 0;
    bit          merr     = 1'b0;
    bit          mon_en   = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    function automatic logic [10:0] ln(input bit en, input int idx, input int val);
        return {en, 2'(idx), 8'(val)};
    endfunction
    function automatic logic [23:0] w_run(input int n);
        return {2'd1, 16'(n), 6'd0};
    endfunction
    function automatic logic [23:0] w_spk(input logic [10:0] l0, input logic [10:0] l1);
        return {2'd2, l0, l1};
    endfunction
    function automatic logic [23:0] w_clr();
        return {2'd3, 22'd0};
    endfunction
    function automatic int sat8(input int s);
        if (s > 127) return 127;
        if (s < -128) return -128;
        return s;
    endfunction
    function automatic logic [23:0] pk(input int p[3]);
        return {8'(p[2]), 8'(p[1]), 8'(p[0])};
    endfunction
    function automatic logic [23:0] pka();
        return {ia.net_inp[2], ia.net_inp[1], ia.net_inp[0]};
    endfunction
    function automatic logic [23:0] pkb();
        return {ib.net_inp[2], ib.net_inp[1], ib.net_inp[0]};
    endfunction
    function automatic logic [7:0] ina(input int i);
        return ia.net_inp[i];
    endfunction
    function automatic logic [7:0] inb(input int i);
        return ib.net_inp[i];
    endfunction

    // Reference model, advanced once per accepted instruction word.
    function automatic void model_accept(input logic [23:0] w);
        int          n, idx, v;
        logic [10:0] f;
        exp_t        e;
        case (w[23:22])
            2'd1: begin
                n = int'(w[21:6]);
                if (n == 0) n = 1;
                for (int k = 0; k < n; k++) begin
                    e.a   = (k == 0) ? pk(pa) : 24'd0;
                    e.b   = (k == 0) ? pk(pb) : 24'd0;
                    e.cyc = 32'(mcyc + 32'(k));
                    e.err = merr;
                    sb.push_back(e);
                end
                mcyc = mcyc + 32'(n);
                pa   = '{default: 0};
                pb   = '{default: 0};
            end
            2'd2: begin
                for (int l = 0; l < 2; l++) begin
                    f   = (l == 0) ? w[21:11] : w[10:0];
                    idx = int'(f[9:8]);
                    v   = int'($signed(f[7:0]));
                    if (f[10]) begin
                        if (idx >= 3) merr = 1'b1;
                        else begin
                            pa[idx] = v;
                            pb[idx] = sat8(pb[idx] + v);
                        end
                    end
                end
            end
            2'd3: begin
                pa   = '{default: 0};
                pb   = '{default: 0};
                merr = 1'b0;
                mcyc = 0;
            end
            default: ;
        endcase
    endfunction

    task automatic drive(input bit v, input logic [23:0] w, input bit nr, output bit acc);
        @(negedge clk);
        ia.src_valid = v; ia.src = w; ia.net_ready = nr;
        ib.src_valid = v; ib.src = w; ib.net_ready = nr;
        #1;
        acc = v && ia.src_ready;
        if (acc) model_accept(w);
    endtask

    task automatic idle(input bit nr);
        bit a;
        drive(1'b0, 24'($urandom), nr, a);
    endtask

    task automatic send(input logic [23:0] w, input int pct);
        bit acc = 1'b0;
        int n   = 0;
        while (!acc && n < 64) begin
            drive(1'b1, w, ($urandom_range(99) < pct), acc);
            n++;
        end
        if (!acc) check("send_timeout", 64'(acc), 1);
    endtask

    // Monitor: every network handshake pops one prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (mon_en) begin
                check("ab_lockstep", {ia.src_ready, ia.net_valid}, {ib.src_ready, ib.net_valid});
                if (ia.net_valid && ia.net_ready) begin
                    if (sb.size() == 0) check("sb_underflow", 64'(ia.net_valid), 0);
                    else begin
                        e = sb.pop_front();
                        check("hs_inp_a", pka(), e.a);
                        check("hs_inp_b", pkb(), e.b);
                        check("hs_cycles_a", cyc_a, e.cyc);
                        check("hs_cycles_b", cyc_b, e.cyc);
                        check("hs_err_a", err_a, e.err);
                        check("hs_err_b", err_b, e.err);
                        check("hs_net_arstn", ia.net_arstn, 1);
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog checks=%0d", checks);
        $fatal(1, "watchdog expired");
    end

    initial begin
        bit          acc, pend;
        logic [3:0]  nrp, nv, sr;
        logic [7:0]  nvs;
        int          r, n;
        logic [23:0] w;

        ia.src_valid = 1'b0; ia.src = '0; ia.net_ready = 1'b0;
        ib.src_valid = 1'b0; ib.src = '0; ib.net_ready = 1'b0;
        pa = '{default: 0};
        pb = '{default: 0};

        repeat (2) @(negedge clk);
        #1;
        check("rst_net_valid", ia.net_valid, 0);
        check("rst_net_arstn", ia.net_arstn, 0);
        check("rst_err", err_a, 0);
        check("rst_cycles", cyc_a, 0);
        check("rst_inp", {pka(), pkb()}, 0);
        check("rst_src_ready", ia.src_ready, 1);
        @(negedge clk);
        arstn = 1'b1;
        #1;
        check("arstn_hold", ia.net_arstn, 0);
        mon_en = 1'b1;
        idle(1'b0);
        check("arstn_rise", ia.net_arstn, 1);

        // RUN 0 behaves as RUN 1
        send(w_run(0), 100);
        idle(1'b1);
        check("run0_valid", ia.net_valid, 1);
        idle(1'b1);
        check("run0_done", ia.net_valid, 0);
        check("run0_cycles", cyc_a, 1);

        // RUN 3 with a stalled network cycle
        send(w_run(3), 100);
        nrp = 4'b1101;
        for (int i = 0; i < 4; i++) begin
            idle(nrp[i]);
            nv[i] = ia.net_valid;
            sr[i] = ia.src_ready;
        end
        check("run3_valid", nv, 4'b1111);
        check("run3_ready", sr, 4'b1000);
        idle(1'b1);
        check("run3_end", ia.net_valid, 0);
        check("run3_cycles", cyc_a, 4);

        // back-to-back RUNs without a bubble
        send(w_run(2), 100);
        pend = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(pend, w_run(2), 1'b1, acc);
            if (acc) pend = 1'b0;
            nvs[i] = ia.net_valid;
        end
        check("b2b_valid", nvs, 8'h0F);
        check("b2b_cycles", cyc_a, 8);

        // saturation (B) versus overwrite (A)
        send(w_spk(ln(1'b1, 0, 100), ln(1'b1, 0, 100)), 100);
        idle(1'b0);
        check("acc_sat_b", inb(0), 8'd127);
        check("ovw_a", ina(0), 8'd100);
        send(w_run(0), 100);
        idle(1'b1);
        idle(1'b1);
        check("acc_clear_b", pkb(), 0);
        check("acc_clear_a", pka(), 0);

        send(w_spk(ln(1'b1, 1, 5), ln(1'b1, 1, -3)), 100);
        idle(1'b0);
        check("ovw_a1", ina(1), 8'hFD);
        check("acc_b1", inb(1), 8'h02);
        check("err_pre", err_a, 0);
        send(w_spk(ln(1'b1, 3, 7), ln(1'b0, 2, 9)), 100);
        idle(1'b0);
        check("err_a", err_a, 1);
        check("err_b", err_b, 1);
        check("err_keep_a", pka(), 24'h00FD00);
        check("err_keep_b", pkb(), 24'h000200);
        send(w_run(1), 100);
        idle(1'b1);
        idle(1'b1);

        // CLR pulses net_arstn for one cycle
        send(w_spk(ln(1'b1, 2, -50), ln(1'b0, 0, 0)), 100);
        send(w_clr(), 100);
        idle(1'b1);
        check("clr_low", ia.net_arstn, 0);
        check("clr_cycles", cyc_a, 0);
        check("clr_err", err_a, 0);
        check("clr_inp", {pka(), pkb()}, 0);
        idle(1'b1);
        check("clr_high", ia.net_arstn, 1);

        // randomized instruction stream
        for (int it = 0; it < 300; it++) begin
            if ($urandom_range(3) == 0) idle(1'($urandom_range(1)));
            r = int'($urandom_range(99));
            if (r < 10)      w = {2'd0, 22'($urandom)};
            else if (r < 45) w = w_run(int'($urandom_range(4)));
            else if (r < 92) w = w_spk(ln($urandom_range(3) != 0, int'($urandom_range(3)), int'($urandom_range(255))),
                                       ln($urandom_range(3) != 0, int'($urandom_range(3)), int'($urandom_range(255))));
            else             w = w_clr();
            send(w, 40 + int'($urandom_range(60)));
        end
        idle(1'b1);
        n = 0;
        while (ia.net_valid && n < 100) begin
            idle(1'b1);
            n++;
        end
        check("drain", ia.net_valid, 0);
        check("final_inp_a", pka(), pk(pa));
        check("final_inp_b", pkb(), pk(pb));
        check("final_err_a", err_a, merr);
        check("final_err_b", err_b, merr);
        check("final_cycles_a", cyc_a, mcyc);
        check("final_cycles_b", cyc_b, mcyc);
        check("sb_empty", sb.size(), 0);

        // asynchronous reset in the middle of a run
        send(w_spk(ln(1'b1, 2, 55), ln(1'b1, 3, 0)), 100);
        send(w_run(5), 100);
        idle(1'b0);
        idle(1'b0);
        check("pre_rst_valid", ia.net_valid, 1);
        mon_en = 1'b0;
        #2;
        arstn = 1'b0;
        #1;
        check("mid_rst_valid", ia.net_valid, 0);
        check("mid_rst_ready", ia.src_ready, 1);
        check("mid_rst_arstn", ia.net_arstn, 0);
        check("mid_rst_err", {err_a, err_b}, 0);
        check("mid_rst_cycles", {cyc_a, cyc_b}, 0);
        check("mid_rst_inp", {pka(), pkb()}, 0);
        sb.delete();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
